// File: rtl/photon_gate_counter.sv
// photon_gate_counter: counts photon pulses over N sync periods,
// publishes each gate count and keeps a saturating running total.
module photon_gate_counter #(
  parameter int CNT_W        = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int SYNC_TIMEOUT = 2_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             iSync,
  input  logic             iPhoton,
  input  logic [2:0]       iActive_Periods_Num,
  input  logic             iAcc_Clear,
  output logic             oData_Update,
  output logic [CNT_W-1:0] oPulse_Counter,
  output logic [CNT_W-1:0] oPulseCounter_Accumulated,
  output logic             oGate_Active,
  output logic             oSync_Lost
);

  localparam int WD_W = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(SYNC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] syncSh;
  logic [SYNC_STAGES-1:0] phSh;
  logic                   syncPrev;
  logic                   phPrev;
  logic                   syncRise;
  logic                   phRise;
  logic [2:0]             perLeft;
  logic [CNT_W-1:0]       cnt;
  logic [WD_W-1:0]        wdog;
  logic [CNT_W-1:0]       gateVal;
  logic [CNT_W-1:0]       accBase;
  logic [CNT_W-1:0]       accNext;
  logic                   gateEnd;
  logic                   timeoutHit;

  function automatic logic [2:0] clampN(input logic [2:0] n);
    logic [2:0] r;
    r = n;
    if (n == 3'd0) r = 3'd1;
    else if (n > 3'd5) r = 3'd5;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] satAdd(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Pin synchronizers and registered rising-edge strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncSh   <= '0;
      phSh     <= '0;
      syncPrev <= 1'b0;
      phPrev   <= 1'b0;
      syncRise <= 1'b0;
      phRise   <= 1'b0;
    end else begin
      syncSh   <= {syncSh[SYNC_STAGES-2:0], iSync};
      phSh     <= {phSh[SYNC_STAGES-2:0], iPhoton};
      syncPrev <= syncSh[SYNC_STAGES-1];
      phPrev   <= phSh[SYNC_STAGES-1];
      syncRise <= syncSh[SYNC_STAGES-1] & ~syncPrev;
      phRise   <= phSh[SYNC_STAGES-1] & ~phPrev;
    end
  end

  always_comb begin
    gateVal    = satAdd(cnt, CNT_W'(phRise));
    timeoutHit = en && (state != IDLE) && !syncRise
                 && (wdog == WD_LAST);
    gateEnd    = en && (state == COUNT) && syncRise
                 && (perLeft == 3'd1);
    accBase    = iAcc_Clear ? '0 : oPulseCounter_Accumulated;
    accNext    = gateEnd ? satAdd(accBase, gateVal) : accBase;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= IDLE;
      perLeft                   <= 3'd0;
      cnt                       <= '0;
      wdog                      <= '0;
      oData_Update              <= 1'b0;
      oPulse_Counter            <= '0;
      oPulseCounter_Accumulated <= '0;
      oGate_Active              <= 1'b0;
      oSync_Lost                <= 1'b0;
    end else begin
      oData_Update              <= 1'b0;
      oPulseCounter_Accumulated <= accNext;
      if (syncRise) oSync_Lost <= 1'b0;
      if (!en) begin
        state        <= IDLE;
        cnt          <= '0;
        wdog         <= '0;
        oGate_Active <= 1'b0;
      end else if (timeoutHit) begin
        // lost sync: drop the partial gate and re-arm
        state        <= ARM;
        cnt          <= '0;
        wdog         <= '0;
        oGate_Active <= 1'b0;
        oSync_Lost   <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            state <= ARM;
            wdog  <= '0;
          end
          ARM: begin
            if (syncRise) begin
              state        <= COUNT;
              perLeft      <= clampN(iActive_Periods_Num);
              cnt          <= '0;
              wdog         <= '0;
              oGate_Active <= 1'b1;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
          COUNT: begin
            if (syncRise) begin
              wdog <= '0;
              if (perLeft == 3'd1) begin
                oPulse_Counter <= gateVal;
                oData_Update   <= 1'b1;
                cnt            <= '0;
                perLeft        <= clampN(iActive_Periods_Num);
              end else begin
                perLeft <= perLeft - 3'd1;
                cnt     <= gateVal;
              end
            end else begin
              wdog <= wdog + 1'b1;
              cnt  <= gateVal;
            end
          end
          default: begin
            state        <= IDLE;
            oGate_Active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_photon_gate_counter.sv
// tb_photon_gate_counter: directed sync/photon stimulus with a
// strobe-driven scoreboard on gate count and accumulator.
module tb_photon_gate_counter;

  localparam int CNT_W = 8;
  localparam int TO    = 400;
  localparam int MAXV  = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             iSync = 1'b0;
  logic             iPhoton = 1'b0;
  logic [2:0]       iActive_Periods_Num = 3'd1;
  logic             iAcc_Clear = 1'b0;
  logic             oData_Update;
  logic [CNT_W-1:0] oPulse_Counter;
  logic [CNT_W-1:0] oPulseCounter_Accumulated;
  logic             oGate_Active;
  logic             oSync_Lost;

  photon_gate_counter #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(2),
    .SYNC_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .iSync(iSync),
    .iPhoton(iPhoton),
    .iActive_Periods_Num(iActive_Periods_Num),
    .iAcc_Clear(iAcc_Clear),
    .oData_Update(oData_Update),
    .oPulse_Counter(oPulse_Counter),
    .oPulseCounter_Accumulated(oPulseCounter_Accumulated),
    .oGate_Active(oGate_Active),
    .oSync_Lost(oSync_Lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  bit   gating = 0;
  int   perLeft = 0;
  int   mCnt = 0;
  int   mAcc = 0;
  int   mLast = 0;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic int clampN(input int n);
    return (n == 0) ? 1 : ((n > 5) ? 5 : n);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // period-level reference: one call per sync rising edge
  function automatic void modelEdge(input int nPh, input bit ph,
                                    input bit clr);
    exp_t e;
    if (!gating) begin
      gating  = 1;
      perLeft = clampN(int'(iActive_Periods_Num));
      mCnt    = 0;
    end else if (perLeft == 1) begin
      mLast   = sat(mCnt + int'(ph));
      mAcc    = clr ? mLast : sat(mAcc + mLast);
      e.cnt   = mLast;
      e.acc   = mAcc;
      sb.push_back(e);
      mCnt    = 0;
      perLeft = clampN(int'(iActive_Periods_Num));
    end else begin
      perLeft--;
      mCnt = sat(mCnt + int'(ph));
    end
    mCnt = sat(mCnt + nPh);
  endfunction

  task automatic period(input int nPh, input bit phEdge = 0,
                        input bit clr = 0);
    modelEdge(nPh, phEdge, clr);
    iSync   = 1'b1;
    iPhoton = phEdge;
    tick(2);
    iPhoton = 1'b0;
    tick(1);
    iAcc_Clear = clr;
    tick(1);
    iAcc_Clear = 1'b0;
    tick(1);
    iSync = 1'b0;
    tick(2);
    for (int i = 0; i < nPh; i++) begin
      iPhoton = 1'b1;
      tick(2);
      iPhoton = 1'b0;
      tick(2);
    end
    tick(13);
  endtask

  always @(negedge clk) begin
    if (rst_n && oData_Update) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe: unexpected update cnt=%0d acc=%0d",
                 oPulse_Counter, oPulseCounter_Accumulated);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_cnt", int'(oPulse_Counter), e.cnt);
        chk("strobe_acc", int'(oPulseCounter_Accumulated), e.acc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("rst_update", int'(oData_Update), 0);
    chk("rst_cnt", int'(oPulse_Counter), 0);
    chk("rst_acc", int'(oPulseCounter_Accumulated), 0);
    chk("rst_gate", int'(oGate_Active), 0);
    chk("rst_lost", int'(oSync_Lost), 0);
    rst_n = 1'b1;
    tick(2);

    // N=1, photons in ARM are ignored
    iActive_Periods_Num = 3'd1;
    en = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      iPhoton = 1'b1;
      tick(2);
      iPhoton = 1'b0;
      tick(2);
    end
    chk("arm_gate", int'(oGate_Active), 0);
    period(7);
    chk("gate_on", int'(oGate_Active), 1);
    period(7);
    period(7);
    chk("t1_acc", int'(oPulseCounter_Accumulated), 14);

    // N=3, then 0 -> 1 and 7 -> 5
    iActive_Periods_Num = 3'd3;
    period(5);
    period(5);
    period(5);
    iActive_Periods_Num = 3'd0;
    period(2);
    chk("n3_cnt", int'(oPulse_Counter), 15);
    period(2);
    iActive_Periods_Num = 3'd7;
    for (int i = 0; i < 5; i++) period(1);
    iActive_Periods_Num = 3'd1;
    period(0);
    chk("n5_cnt", int'(oPulse_Counter), 5);

    // photon coincident with terminal sync edge
    period(4);
    period(0, 1'b1);
    chk("coinc_cnt", int'(oPulse_Counter), 5);
    period(0);
    chk("next_zero", int'(oPulse_Counter), 0);

    // clear coincident with gate end, then saturation
    period(9);
    period(0, 1'b0, 1'b1);
    chk("clr_acc", int'(oPulseCounter_Accumulated), 9);
    iActive_Periods_Num = 3'd5;
    for (int i = 0; i < 10; i++) period(30);
    period(60);
    chk("acc_sat", int'(oPulseCounter_Accumulated), 255);
    for (int i = 0; i < 4; i++) period(60);
    iActive_Periods_Num = 3'd1;
    period(0);
    chk("cnt_sat", int'(oPulse_Counter), 255);
    iAcc_Clear = 1'b1;
    tick(1);
    iAcc_Clear = 1'b0;
    mAcc = 0;
    chk("clr_alone", int'(oPulseCounter_Accumulated), 0);

    // sync loss mid-gate
    tick(TO - 21);
    chk("lost_early", int'(oSync_Lost), 0);
    tick(8);
    chk("lost_set", int'(oSync_Lost), 1);
    chk("lost_gate", int'(oGate_Active), 0);
    gating = 0;
    mCnt = 0;
    period(6);
    chk("lost_clr", int'(oSync_Lost), 0);
    chk("resume_gate", int'(oGate_Active), 1);
    period(3);

    // en=0 mid-gate holds outputs
    en = 1'b0;
    tick(2);
    gating = 0;
    mCnt = 0;
    chk("dis_gate", int'(oGate_Active), 0);
    chk("dis_cnt", int'(oPulse_Counter), 6);
    chk("dis_acc", int'(oPulseCounter_Accumulated), 6);
    tick(50);
    chk("dis_hold", int'(oPulse_Counter), 6);
    chk("dis_nolost", int'(oSync_Lost), 0);
    en = 1'b1;
    tick(2);
    period(2);
    period(0);
    chk("re_acc", int'(oPulseCounter_Accumulated), 8);

    // async reset mid-COUNT
    period(5);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("arst_update", int'(oData_Update), 0);
    chk("arst_cnt", int'(oPulse_Counter), 0);
    chk("arst_acc", int'(oPulseCounter_Accumulated), 0);
    chk("arst_gate", int'(oGate_Active), 0);
    chk("arst_lost", int'(oSync_Lost), 0);
    gating = 0;
    mCnt = 0;
    mAcc = 0;
    mLast = 0;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
